// File: rtl/wbs_host_master.sv
// Wishbone classic single-transfer initiator: turns a valid/ready command stream into one
// bus cycle per command and returns read data or a timeout error on a response stream.
module wbs_host_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int SEL_WIDTH      = 4,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_we,
   input  logic [ADDR_WIDTH-1:0] cmd_adr,
   input  logic [DATA_WIDTH-1:0] cmd_dat,
   input  logic [SEL_WIDTH-1:0]  cmd_sel,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_dat,
   output logic                  rsp_err,
   output logic                  wbm_cyc_o,
   output logic                  wbm_stb_o,
   output logic                  wbm_we_o,
   output logic [SEL_WIDTH-1:0]  wbm_sel_o,
   output logic [ADDR_WIDTH-1:0] wbm_adr_o,
   output logic [DATA_WIDTH-1:0] wbm_dat_o,
   input  logic [DATA_WIDTH-1:0] wbm_dat_i,
   input  logic                  wbm_ack_i,
   output logic                  busy
);

   // A disabled timeout yields a zero-width counter; keep at least one bit.
   localparam int CNT_W = (TO_WIDTH < 1) ? 1 : TO_WIDTH;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] to_cnt;
   logic             timed_out;

   assign timed_out = (TIMEOUT_CYCLES != 0) && (to_cnt == CNT_LAST);

   // NOTE: every register here uses non-blocking assignment so all state updates
   // see the same pre-edge values; blocking would create order-dependent races.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: next-state gets a default before the case so no path leaves it unassigned
   // (an unassigned path in always_comb infers a latch).
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (cmd_valid)              state_nxt = BUS;
         BUS:     if (wbm_ack_i || timed_out) state_nxt = RESP;
         RESP:    if (rsp_ready)              state_nxt = IDLE;
         default:                             state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wbm_we_o  <= 1'b0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
         wbm_sel_o <= '0;
         rsp_dat   <= '0;
         rsp_err   <= 1'b0;
         to_cnt    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  wbm_we_o  <= cmd_we;
                  wbm_adr_o <= cmd_adr;
                  wbm_dat_o <= cmd_dat;
                  wbm_sel_o <= cmd_sel;
                  to_cnt    <= '0;
               end
            end
            BUS: begin
               // Ack takes priority over a timeout on the same edge.
               if (wbm_ack_i) begin
                  rsp_dat <= wbm_we_o ? '0 : wbm_dat_i;
                  rsp_err <= 1'b0;
               end else if (timed_out) begin
                  rsp_dat <= '0;
                  rsp_err <= 1'b1;
               end else begin
                  to_cnt  <= to_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Bus and handshake controls decode straight from state so they drop on the
   // same edge that leaves BUS, including a reset edge.
   assign cmd_ready = (state == IDLE);
   assign wbm_cyc_o = (state == BUS);
   assign wbm_stb_o = (state == BUS);
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_wbs_host_master.sv
// Directed bench for wbs_host_master: write/read, zero-wait, timeout with late ack,
// response backpressure, reset mid-cycle and queued back-to-back writes.
module tb_wbs_host_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_adr, cmd_dat;
   logic [3:0]  cmd_sel;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_dat;
   logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
   logic        wbm_ack_i, busy;

   int checks = 0;
   int errors = 0;
   int stb_cnt = 0;
   int stb_rise = 0;
   logic stb_q = 1'b0;
   int base_cnt, base_rise;

   always #5 clk = ~clk;

   wbs_host_master #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy)
   );

   // Counts strobe-high edges and strobe rising transitions seen at clock edges.
   always @(posedge clk) begin
      if (wbm_stb_o) stb_cnt++;
      if (wbm_stb_o && !stb_q) stb_rise++;
      stb_q = wbm_stb_o;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic we, input logic [31:0] adr, input logic [31:0] dat);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_adr   = adr;
      cmd_dat   = dat;
      cmd_sel   = 4'hF;
   endtask

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
      cmd_sel = '0; rsp_ready = 1'b0; wbm_dat_i = '0; wbm_ack_i = 1'b0;
      tick(); tick();
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
      check("rst_stb", 32'(wbm_stb_o), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_dat", rsp_dat, 32'd0);
      check("rst_adr", wbm_adr_o, 32'd0);
      rst_n = 1'b1;
      tick();

      // 1: write, two wait states
      wbm_dat_i = 32'h1234_5678;
      base_cnt = stb_cnt;
      send(1'b1, 32'h3000_0000, 32'h0000_0003);
      tick();
      cmd_valid = 1'b0;
      check("t1_stb_c1", 32'(wbm_stb_o), 32'd1);
      check("t1_cyc_c1", 32'(wbm_cyc_o), 32'd1);
      check("t1_we", 32'(wbm_we_o), 32'd1);
      check("t1_adr", wbm_adr_o, 32'h3000_0000);
      check("t1_dat", wbm_dat_o, 32'h0000_0003);
      check("t1_sel", 32'(wbm_sel_o), 32'hF);
      check("t1_cmd_ready", 32'(cmd_ready), 32'd0);
      check("t1_busy", 32'(busy), 32'd1);
      tick();
      check("t1_stb_c2", 32'(wbm_stb_o), 32'd1);
      check("t1_adr_c2", wbm_adr_o, 32'h3000_0000);
      tick();
      check("t1_stb_c3", 32'(wbm_stb_o), 32'd1);
      check("t1_dat_c3", wbm_dat_o, 32'h0000_0003);
      wbm_ack_i = 1'b1;
      tick();
      wbm_ack_i = 1'b0;
      check("t1_stb_done", 32'(wbm_stb_o), 32'd0);
      check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t1_rsp_err", 32'(rsp_err), 32'd0);
      check("t1_rsp_dat", rsp_dat, 32'd0);
      check("t1_stb_cycles", 32'(stb_cnt - base_cnt), 32'd3);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("t1_consumed", 32'(rsp_valid), 32'd0);
      check("t1_idle_ready", 32'(cmd_ready), 32'd1);

      // 2: read, zero wait states
      base_cnt = stb_cnt;
      send(1'b0, 32'h3000_0004, 32'h0);
      tick();
      cmd_valid = 1'b0;
      check("t2_stb", 32'(wbm_stb_o), 32'd1);
      check("t2_we", 32'(wbm_we_o), 32'd0);
      check("t2_adr", wbm_adr_o, 32'h3000_0004);
      wbm_ack_i = 1'b1; wbm_dat_i = 32'hDEAD_BEEF;
      tick();
      wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
      check("t2_stb_done", 32'(wbm_stb_o), 32'd0);
      check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t2_rsp_dat", rsp_dat, 32'hDEAD_BEEF);
      check("t2_rsp_err", 32'(rsp_err), 32'd0);
      check("t2_stb_cycles", 32'(stb_cnt - base_cnt), 32'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // 3: timeout after 8 strobe cycles, late ack ignored
      base_cnt = stb_cnt;
      wbm_dat_i = 32'h7777_7777;
      send(1'b0, 32'h3000_0008, 32'h0);
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check("t3_stb_c8", 32'(wbm_stb_o), 32'd1);
      tick();
      check("t3_stb_abort", 32'(wbm_stb_o), 32'd0);
      check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
      check("t3_rsp_err", 32'(rsp_err), 32'd1);
      check("t3_rsp_dat", rsp_dat, 32'd0);
      check("t3_stb_cycles", 32'(stb_cnt - base_cnt), 32'd8);
      tick();
      wbm_ack_i = 1'b1;
      tick();
      wbm_ack_i = 1'b0;
      check("t3_late_valid", 32'(rsp_valid), 32'd1);
      check("t3_late_err", 32'(rsp_err), 32'd1);
      check("t3_late_dat", rsp_dat, 32'd0);
      check("t3_late_stb", 32'(wbm_stb_o), 32'd0);
      check("t3_late_busy", 32'(busy), 32'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("t3_consumed", 32'(rsp_valid), 32'd0);

      // 4: response backpressure with a pending command
      send(1'b0, 32'h3000_000C, 32'h0);
      tick();
      cmd_valid = 1'b0;
      wbm_ack_i = 1'b1; wbm_dat_i = 32'hCAFE_F00D;
      tick();
      wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
      send(1'b1, 32'h3000_0010, 32'h0000_0055);
      for (int i = 0; i < 5; i++) begin
         check("t4_hold_valid", 32'(rsp_valid), 32'd1);
         check("t4_hold_dat", rsp_dat, 32'hCAFE_F00D);
         check("t4_hold_ready", 32'(cmd_ready), 32'd0);
         check("t4_hold_stb", 32'(wbm_stb_o), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("t4_idle_ready", 32'(cmd_ready), 32'd1);
      check("t4_idle_stb", 32'(wbm_stb_o), 32'd0);
      check("t4_dat_retained", rsp_dat, 32'hCAFE_F00D);
      tick();
      cmd_valid = 1'b0;
      check("t4_next_stb", 32'(wbm_stb_o), 32'd1);
      check("t4_next_adr", wbm_adr_o, 32'h3000_0010);
      check("t4_next_we", 32'(wbm_we_o), 32'd1);
      wbm_ack_i = 1'b1;
      tick();
      wbm_ack_i = 1'b0;
      check("t4_next_rsp", 32'(rsp_valid), 32'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // 5: reset while the strobe is high
      send(1'b0, 32'h3000_0020, 32'h0);
      tick();
      cmd_valid = 1'b0;
      check("t5_stb_before", 32'(wbm_stb_o), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t5_stb_rst", 32'(wbm_stb_o), 32'd0);
      check("t5_cyc_rst", 32'(wbm_cyc_o), 32'd0);
      check("t5_valid_rst", 32'(rsp_valid), 32'd0);
      check("t5_ready_rst", 32'(cmd_ready), 32'd1);
      check("t5_busy_rst", 32'(busy), 32'd0);
      wbm_ack_i = 1'b1;
      tick();
      wbm_ack_i = 1'b0;
      tick();
      check("t5_no_rsp", 32'(rsp_valid), 32'd0);
      send(1'b1, 32'h3000_0024, 32'h0000_00A5);
      tick();
      cmd_valid = 1'b0;
      check("t5_next_stb", 32'(wbm_stb_o), 32'd1);
      check("t5_next_adr", wbm_adr_o, 32'h3000_0024);
      check("t5_next_dat", wbm_dat_o, 32'h0000_00A5);
      wbm_ack_i = 1'b1;
      tick();
      wbm_ack_i = 1'b0;
      check("t5_next_rsp", 32'(rsp_valid), 32'd1);
      check("t5_next_err", 32'(rsp_err), 32'd0);
      rsp_ready = 1'b1;
      tick();

      // 6: four queued writes, one wait state each, rsp_ready always high
      base_rise = stb_rise;
      base_cnt  = stb_cnt;
      for (int i = 0; i < 4; i++) begin
         send(1'b1, 32'h3000_1000 + 32'(i * 4), 32'h100 + 32'(i));
         check("t6_idle_ready", 32'(cmd_ready), 32'd1);
         tick();
         if (i < 3) send(1'b1, 32'h3000_1000 + 32'((i + 1) * 4), 32'h100 + 32'(i + 1));
         else       cmd_valid = 1'b0;
         check("t6_stb_c1", 32'(wbm_stb_o), 32'd1);
         check("t6_adr", wbm_adr_o, 32'h3000_1000 + 32'(i * 4));
         check("t6_dat", wbm_dat_o, 32'h100 + 32'(i));
         tick();
         check("t6_stb_c2", 32'(wbm_stb_o), 32'd1);
         check("t6_busy_ready", 32'(cmd_ready), 32'd0);
         wbm_ack_i = 1'b1;
         tick();
         wbm_ack_i = 1'b0;
         check("t6_rsp_valid", 32'(rsp_valid), 32'd1);
         check("t6_rsp_err", 32'(rsp_err), 32'd0);
         check("t6_stb_gap", 32'(wbm_stb_o), 32'd0);
         tick();
         check("t6_consumed", 32'(rsp_valid), 32'd0);
      end
      tick();
      check("t6_issue_count", 32'(stb_rise - base_rise), 32'd4);
      check("t6_stb_cycles", 32'(stb_cnt - base_cnt), 32'd8);
      rsp_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
